// File: rtl/uart_pkg.sv
// Shared UART definitions: line-format codes (common with uart_tx) and receiver states.
package uart_pkg;

    // Parity modes as carried on parity_config
    localparam logic [2:0] PARITY_NONE  = 3'd0;
    localparam logic [2:0] PARITY_EVEN  = 3'd1;
    localparam logic [2:0] PARITY_ODD   = 3'd2;
    localparam logic [2:0] PARITY_MARK  = 3'd3;
    localparam logic [2:0] PARITY_SPACE = 3'd4;

    // Stop-bit modes as carried on stop_bits_config
    localparam logic STOP_BITS_ONE = 1'b0;
    localparam logic STOP_BITS_TWO = 1'b1;

    // Receiver frame states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } rx_state_t;

    // A parity bit is present on the line only for the four defined parity modes
    function automatic logic parity_enabled(input logic [2:0] mode);
        return (mode == PARITY_EVEN) || (mode == PARITY_ODD) ||
               (mode == PARITY_MARK) || (mode == PARITY_SPACE);
    endfunction

    // Parity bit the transmitter should have sent, given the XOR of the data bits
    function automatic logic expected_parity(input logic [2:0] mode, input logic data_xor);
        logic exp_bit;
        case (mode)
            PARITY_EVEN: exp_bit = data_xor;
            PARITY_ODD:  exp_bit = ~data_xor;
            PARITY_MARK: exp_bit = 1'b1;
            default:     exp_bit = 1'b0;
        endcase
        return exp_bit;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// AXI-Stream channel carrying received words and their error flags.
interface uart_rx_if #(
    parameter int WORD_SIZE = 8
);
    logic [WORD_SIZE-1:0] tdata;
    logic [1:0]           tuser;   // [0] parity_err, [1] frame_err
    logic                 tvalid;
    logic                 tready;

    modport master (output tdata, output tuser, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with AXI-Stream style ports; full FIFO refuses a push even when popped that cycle.
module uart_fifo #(
    parameter int DATA_WIDTH = 10,
    parameter int DATA_DEPTH = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready
);
    localparam int AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam int CW = $clog2(DATA_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DATA_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign s_tready = (count != CW'(DATA_DEPTH));
    assign m_tvalid = (count != '0);
    assign m_tdata  = mem[rd_ptr];
    assign do_push  = s_tvalid & s_tready;
    assign do_pop   = m_tvalid & m_tready;

    // Storage write
    // NOTE: the data array is deliberately not reset; occupancy is tracked by count, so stale contents are never presented.
    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    // Pointer and occupancy bookkeeping
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rxd, samples each bit at mid-period, deframes, buffers in uart_fifo.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_PRESCALER = 12,
    parameter int PARITY         = 0,
    parameter int WORD_SIZE      = 8,
    parameter int STOP_BITS      = 0,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        rxd,
    output logic        rtsn,
    uart_rx_if.master   m_axis,
    output logic        busy,
    output logic        overrun,
    input  logic [15:0] prescaler_config,
    input  logic [2:0]  parity_config,
    input  logic        stop_bits_config
);
    localparam int FW = WORD_SIZE + 2;
    localparam int BW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

    rx_state_t            state;
    rx_state_t            state_next;
    logic                 rxd_meta;
    logic                 rxs;
    logic                 rxs_d;
    logic [15:0]          cfg_prescaler;
    logic [2:0]           cfg_parity;
    logic                 cfg_stop_bits;
    logic [15:0]          timer;
    logic                 tick;
    logic [WORD_SIZE-1:0] shreg;
    logic [BW-1:0]        bitcnt;
    logic                 data_xor;
    logic                 parity_err;
    logic                 frame_err;
    logic                 second_stop;
    logic                 load_half;
    logic                 load_full;
    logic                 take_data;
    logic                 take_par;
    logic                 take_stop;
    logic                 push;
    logic                 fifo_s_tready;
    logic [FW-1:0]        fifo_s_tdata;
    logic [FW-1:0]        fifo_m_tdata;

    assign tick = (timer == 16'd0);
    assign busy = (state != IDLE);

    // Input synchroniser plus one history stage for falling-edge detection
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rxd_meta <= 1'b1;
            rxs      <= 1'b1;
            rxs_d    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxs      <= rxd_meta;
            rxs_d    <= rxs;
        end
    end

    // FSM state register
    always_ff @(posedge aclk) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_next;
    end

    // FSM next state and per-cycle datapath strobes
    // NOTE: every output gets a default before the case so no path leaves a value held, which would infer a latch.
    always_comb begin
        state_next = state;
        load_half  = 1'b0;
        load_full  = 1'b0;
        take_data  = 1'b0;
        take_par   = 1'b0;
        take_stop  = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (rxs_d && !rxs) begin
                    load_half  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    if (rxs) begin
                        state_next = IDLE;
                    end else begin
                        load_full  = 1'b1;
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    take_data = 1'b1;
                    load_full = 1'b1;
                    if (bitcnt == BW'(WORD_SIZE - 1)) begin
                        state_next = parity_enabled(cfg_parity) ? PAR : STOP;
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    take_par   = 1'b1;
                    load_full  = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    take_stop = 1'b1;
                    if (cfg_stop_bits == STOP_BITS_TWO && !second_stop) begin
                        load_full = 1'b1;
                    end else begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line configuration tracks the inputs while idle and is frozen for the frame
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cfg_prescaler <= 16'(BAUD_PRESCALER);
            cfg_parity    <= 3'(PARITY);
            cfg_stop_bits <= 1'(STOP_BITS);
        end else if (state == IDLE) begin
            cfg_prescaler <= prescaler_config;
            cfg_parity    <= parity_config;
            cfg_stop_bits <= stop_bits_config;
        end
    end

    // Bit timer: half period to reach mid start bit, then full periods
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            timer <= 16'd0;
        end else if (load_half) begin
            timer <= (cfg_prescaler >> 1) - 16'd1;
        end else if (load_full) begin
            timer <= cfg_prescaler - 16'd1;
        end else if (state != IDLE && !tick) begin
            timer <= timer - 16'd1;
        end
    end

    // Deframing datapath: shift register, running parity, error flags
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            shreg       <= '0;
            bitcnt      <= '0;
            data_xor    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            second_stop <= 1'b0;
        end else if (load_half) begin
            bitcnt      <= '0;
            data_xor    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            second_stop <= 1'b0;
        end else begin
            if (take_data) begin
                shreg    <= {rxs, shreg[WORD_SIZE-1:1]};
                data_xor <= data_xor ^ rxs;
                bitcnt   <= bitcnt + BW'(1);
            end
            if (take_par) begin
                parity_err <= (rxs != expected_parity(cfg_parity, data_xor));
            end
            if (take_stop) begin
                frame_err   <= frame_err | ~rxs;
                second_stop <= 1'b1;
            end
        end
    end

    // Flow-control and overrun status, registered
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rtsn    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            rtsn    <= ~fifo_s_tready;
            overrun <= push & ~fifo_s_tready;
        end
    end

    // The final stop sample joins frame_err in the same cycle the word is pushed
    assign fifo_s_tdata = {frame_err | ~rxs, parity_err, shreg};

    uart_fifo #(
        .DATA_WIDTH (FW),
        .DATA_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tdata  (fifo_s_tdata),
        .s_tvalid (push),
        .s_tready (fifo_s_tready),
        .m_tdata  (fifo_m_tdata),
        .m_tvalid (m_axis.tvalid),
        .m_tready (m_axis.tready)
    );

    assign m_axis.tdata = fifo_m_tdata[WORD_SIZE-1:0];
    assign m_axis.tuser = fifo_m_tdata[FW-1:WORD_SIZE];

endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed bench for uart_rx with a queue-based scoreboard.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int WS    = 8;
    localparam int DEPTH = 16;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        rxd = 1'b1;
    logic        rtsn;
    logic        busy;
    logic        overrun;
    logic [15:0] prescaler_config = 16'd16;
    logic [2:0]  parity_config = PARITY_EVEN;
    logic        stop_bits_config = 1'b0;

    uart_rx_if #(.WORD_SIZE(WS)) m_axis ();

    uart_rx #(
        .BAUD_PRESCALER (12),
        .PARITY         (0),
        .WORD_SIZE      (WS),
        .STOP_BITS      (0),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .rxd              (rxd),
        .rtsn             (rtsn),
        .m_axis           (m_axis),
        .busy             (busy),
        .overrun          (overrun),
        .prescaler_config (prescaler_config),
        .parity_config    (parity_config),
        .stop_bits_config (stop_bits_config)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad = 0;
    int beats = 0;
    int ovr_cnt = 0;
    int rdy_mode = 1;          // 0 = hold low, 1 = hold high, 2 = random
    logic [9:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: expected {frame_err, parity_err, data} from what was put on the line
    function automatic logic [9:0] ref_word(input logic [7:0] d, input logic [2:0] pm,
                                            input logic par_bit, input logic s1,
                                            input logic s2, input logic two);
        int   ones;
        logic want;
        logic has;
        logic pe;
        logic fe;
        ones = $countones(d);
        has  = (pm >= 3'd1) && (pm <= 3'd4);
        case (pm)
            3'd1:    want = (ones % 2 == 1);   // even: total count of ones even
            3'd2:    want = (ones % 2 == 0);   // odd: total count of ones odd
            3'd3:    want = 1'b1;
            default: want = 1'b0;
        endcase
        pe = has && (par_bit != want);
        fe = !s1 || (two && !s2);
        return {fe, pe, d};
    endfunction

    function automatic logic good_parity(input logic [7:0] d, input logic [2:0] pm);
        logic [9:0] w;
        w = ref_word(d, pm, 1'b0, 1'b1, 1'b1, 1'b0);
        return w[8];   // parity bit 0 was wrong exactly when the correct bit is 1
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [2:0] pm, input logic par_bit,
                              input logic s1, input logic s2, input logic two, input int p);
        rxd = 1'b0;
        cyc(p);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            cyc(p);
        end
        if (pm >= 3'd1 && pm <= 3'd4) begin
            rxd = par_bit;
            cyc(p);
        end
        rxd = s1;
        cyc(p);
        if (two) begin
            rxd = s2;
            cyc(p);
        end
    endtask

    task automatic expect_and_send(input logic [7:0] d, input logic [2:0] pm, input logic par_bit,
                                   input logic s1, input logic s2, input logic two, input int p);
        exp_q.push_back(ref_word(d, pm, par_bit, s1, s2, two));
        send_frame(d, pm, par_bit, s1, s2, two, p);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400 && busy; i++) cyc(1);
        check(name, busy, 0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) cyc(1);
        cyc(2);
        check(name, exp_q.size(), 0);
    endtask

    task automatic set_cfg(input int p, input logic [2:0] pm, input logic two);
        prescaler_config = 16'(p);
        parity_config    = pm;
        stop_bits_config = two;
        cyc(2);
    endtask

    // tready driver
    initial begin
        m_axis.tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0:       m_axis.tready = 1'b0;
                1:       m_axis.tready = 1'b1;
                default: m_axis.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares each accepted beat against the scoreboard and checks hold stability
    initial begin
        logic       hold;
        logic [9:0] held;
        logic [9:0] act;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge aclk);
            if (overrun) ovr_cnt++;
            act = {m_axis.tuser, m_axis.tdata};
            if (!aresetn) begin
                hold = 1'b0;
            end else if (m_axis.tvalid) begin
                if (hold) check("axis_stable", act, held);
                if (m_axis.tready) begin
                    beats++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word: got %0h expected none at %0t", act, $time);
                    end else begin
                        check("word", act, exp_q.pop_front());
                    end
                end
                hold = !m_axis.tready;
                held = act;
            end else begin
                if (hold) check("axis_valid_held", m_axis.tvalid, 1);
                hold = 1'b0;
            end
        end
    end

    // Watchdog: the run must never hang
    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0;
        int o0;
        int p;
        logic [2:0] pm;
        logic two;
        logic [7:0] d;
        logic pb;
        logic s1;
        logic s2;

        // Reset state
        aresetn = 1'b0;
        cyc(4);
        check("rst_tvalid", m_axis.tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rtsn", rtsn, 0);
        aresetn = 1'b1;
        cyc(3);
        check("post_rst_busy", busy, 0);

        // T1: even parity, correct parity bit
        set_cfg(16, PARITY_EVEN, 1'b0);
        b0 = beats;
        expect_and_send(8'hA5, PARITY_EVEN, 1'b0, 1'b1, 1'b1, 1'b0, 16);
        rxd = 1'b1;
        wait_idle("t1_idle");
        drain("t1_drain");
        check("t1_beats", beats - b0, 1);

        // T2: odd parity with wrong parity bit
        set_cfg(16, PARITY_ODD, 1'b0);
        expect_and_send(8'h3C, PARITY_ODD, 1'b0, 1'b1, 1'b1, 1'b0, 16);
        rxd = 1'b1;
        wait_idle("t2_idle");
        drain("t2_drain");

        // T3: stop bit low, then line held low must not retrigger
        set_cfg(16, PARITY_NONE, 1'b0);
        b0 = beats;
        expect_and_send(8'h55, PARITY_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 16);
        cyc(40);
        check("t3_no_retrigger_busy", busy, 0);
        drain("t3_drain");
        check("t3_beats", beats - b0, 1);
        rxd = 1'b1;
        cyc(32);

        // T4: short low glitch is a false start
        set_cfg(16, PARITY_EVEN, 1'b0);
        b0 = beats;
        rxd = 1'b0;
        cyc(5);
        check("t4_busy_set", busy, 1);
        rxd = 1'b1;
        for (int i = 0; i < 8 && busy; i++) cyc(1);
        check("t4_busy_clear", busy, 0);
        cyc(40);
        check("t4_no_word", beats - b0, 0);

        // T5: FIFO fill with tready low, overflow by one, then drain in order
        rdy_mode = 0;
        cyc(2);
        set_cfg(8, PARITY_NONE, 1'b0);
        o0 = ovr_cnt;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) expect_and_send(8'(i), PARITY_NONE, 1'b0, 1'b1, 1'b1, 1'b0, 8);
            else        send_frame(8'(i), PARITY_NONE, 1'b0, 1'b1, 1'b1, 1'b0, 8);
            rxd = 1'b1;
            wait_idle("t5_idle");
            cyc(3);
            if (i == 14) check("t5_rtsn_15", rtsn, 0);
            if (i == 15) check("t5_rtsn_16", rtsn, 1);
        end
        check("t5_overrun_once", ovr_cnt - o0, 1);
        check("t5_rtsn_full", rtsn, 1);
        rdy_mode = 1;
        drain("t5_drain");
        check("t5_rtsn_after_drain", rtsn, 0);

        // T6: reset mid-frame, partial word is lost
        set_cfg(16, PARITY_EVEN, 1'b0);
        b0 = beats;
        rxd = 1'b0;
        cyc(16);
        rxd = 1'b1;
        cyc(16 * 3);
        check("t6_busy_mid", busy, 1);
        aresetn = 1'b0;
        cyc(2);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_tvalid", m_axis.tvalid, 0);
        aresetn = 1'b1;
        cyc(16 * 8);
        expect_and_send(8'h12, PARITY_EVEN, 1'b0, 1'b1, 1'b1, 1'b0, 16);
        rxd = 1'b1;
        wait_idle("t6_idle");
        drain("t6_drain");
        check("t6_beats", beats - b0, 1);

        // Back-to-back frames, two stop bits, no idle gap
        set_cfg(10, PARITY_ODD, 1'b1);
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            expect_and_send(d, PARITY_ODD, good_parity(d, PARITY_ODD), 1'b1, 1'b1, 1'b1, 10);
        end
        rxd = 1'b1;
        wait_idle("b2b_idle");
        drain("b2b_drain");

        // Randomised frames with random tready
        rdy_mode = 2;
        for (int n = 0; n < 30; n++) begin
            p   = $urandom_range(4, 24);
            pm  = 3'($urandom_range(0, 4));
            two = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            pb  = good_parity(d, pm) ^ ($urandom_range(0, 3) == 0);
            s1  = ($urandom_range(0, 5) != 0);
            s2  = ($urandom_range(0, 5) != 0);
            wait_idle("rnd_idle_before");
            set_cfg(p, pm, two);
            expect_and_send(d, pm, pb, s1, s2, two, p);
            rxd = 1'b1;
            cyc($urandom_range(1, p));
        end
        wait_idle("rnd_idle_end");
        rdy_mode = 1;
        drain("rnd_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
